dm_wait_ctrl: RTL

//  Parametrised data memory with a valid/ready request/response handshake and a configurable

---
 rtl/dm_wait_ctrl_pkg.sv | 30 +++
 rtl/dm_wait_ctrl_lane.sv | 55 +++++
 rtl/dm_wait_ctrl.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/dm_wait_ctrl_pkg.sv
// Shared codes for the wait-state data memory: access types, exception codes, FSM states.
package dm_wait_ctrl_pkg;

  localparam logic [2:0] DM_B  = 3'b000;
  localparam logic [2:0] DM_H  = 3'b001;
  localparam logic [2:0] DM_W  = 3'b010;
  localparam logic [2:0] DM_BU = 3'b100;
  localparam logic [2:0] DM_HU = 3'b101;

  localparam logic [1:0] DM_EXC_NONE     = 2'd0;
  localparam logic [1:0] DM_EXC_MISALIGN = 2'd1;
  localparam logic [1:0] DM_EXC_RANGE    = 2'd2;
  localparam logic [1:0] DM_EXC_ILLEGAL  = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } dm_state_t;

  // Unsigned variants only make sense for loads.
  function automatic logic dm_type_ok(input logic [2:0] typ, input logic we);
    case (typ)
      DM_W, DM_H, DM_B: dm_type_ok = 1'b1;
      DM_HU, DM_BU:     dm_type_ok = ~we;
      default:          dm_type_ok = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/dm_wait_ctrl_lane.sv
// Byte/half lane handling: merges store data into the old word and extracts load data.
module dm_wait_ctrl_lane
  import dm_wait_ctrl_pkg::*;
(
  input  logic [31:0] old_word,
  input  logic [2:0]  typ,
  input  logic [1:0]  byte_sel,
  input  logic [31:0] wdata,
  output logic [31:0] wr_word,
  output logic [31:0] rd_data
);

  logic [15:0] half_old;
  logic [7:0]  byte_old;

  always_comb begin
    half_old = byte_sel[1] ? old_word[31:16] : old_word[15:0];
    case (byte_sel)
      2'd0:    byte_old = old_word[7:0];
      2'd1:    byte_old = old_word[15:8];
      2'd2:    byte_old = old_word[23:16];
      default: byte_old = old_word[31:24];
    endcase
  end

  always_comb begin
    wr_word = old_word;
    rd_data = '0;
    case (typ)
      DM_W: begin
        wr_word = wdata;
        rd_data = old_word;
      end
      DM_H, DM_HU: begin
        if (byte_sel[1]) wr_word[31:16] = wdata[15:0];
        else             wr_word[15:0]  = wdata[15:0];
        rd_data = {{16{half_old[15] & (typ == DM_H)}}, half_old};
      end
      DM_B, DM_BU: begin
        case (byte_sel)
          2'd0:    wr_word[7:0]   = wdata[7:0];
          2'd1:    wr_word[15:8]  = wdata[7:0];
          2'd2:    wr_word[23:16] = wdata[7:0];
          default: wr_word[31:24] = wdata[7:0];
        endcase
        rd_data = {{24{byte_old[7] & (typ == DM_B)}}, byte_old};
      end
      default: begin
        wr_word = old_word;
        rd_data = '0;
      end
    endcase
  end

endmodule

// File: rtl/dm_wait_ctrl.sv
// Data memory with valid/ready request/response handshake and LATENCY access wait states.
//  state   | meaning
//  ST_IDLE | req_ready high, waiting for a request
//  ST_WAIT | request captured, counting down wait states
//  ST_RESP | response presented, held until resp_ready
module dm_wait_ctrl
  import dm_wait_ctrl_pkg::*;
#(
  parameter int          ADDR_W    = 10,
  parameter logic [31:0] BASE_ADDR = 32'h0,
  parameter int          LATENCY   = 1,
  parameter int          DISPLAY   = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_type,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [31:0] req_pc,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic [1:0]  resp_exc
);

  localparam int   DEPTH    = 2 ** ADDR_W;
  localparam logic ZERO_LAT = (LATENCY == 0);

  dm_state_t   state;
  logic [3:0]  cnt;
  logic        we_q;
  logic [2:0]  type_q;
  logic [31:0] addr_q, wdata_q, pc_q;

  logic        c_we;
  logic [2:0]  c_type;
  logic [31:0] c_addr, c_wdata, c_pc;
  logic [31:0] offset;
  logic [ADDR_W-1:0] word_idx;
  logic [31:0] old_word, merged, rd_ext;
  logic [1:0]  exc;
  logic        commit, mem_we;

  logic [31:0]      mem [DEPTH];
  // A word reads as zero until first written since reset, so reset clears the array.
  logic [DEPTH-1:0] written;

  // With zero latency the commit uses the request on the bus, otherwise the captured copy.
  assign c_we    = (state == ST_IDLE) ? req_we    : we_q;
  assign c_type  = (state == ST_IDLE) ? req_type  : type_q;
  assign c_addr  = (state == ST_IDLE) ? req_addr  : addr_q;
  assign c_wdata = (state == ST_IDLE) ? req_wdata : wdata_q;
  assign c_pc    = (state == ST_IDLE) ? req_pc    : pc_q;

  assign offset   = c_addr - BASE_ADDR;
  assign word_idx = offset[ADDR_W+1:2];
  assign old_word = written[word_idx] ? mem[word_idx] : 32'h0;

  always_comb begin
    exc = DM_EXC_NONE;
    if (!dm_type_ok(c_type, c_we))
      exc = DM_EXC_ILLEGAL;
    else if ((c_addr < BASE_ADDR) || (offset[31:ADDR_W+2] != '0))
      exc = DM_EXC_RANGE;
    else if ((c_type == DM_W) && (c_addr[1:0] != 2'b00))
      exc = DM_EXC_MISALIGN;
    else if (((c_type == DM_H) || (c_type == DM_HU)) && c_addr[0])
      exc = DM_EXC_MISALIGN;
  end

  assign commit = (state == ST_IDLE && req_valid && ZERO_LAT) ||
                  (state == ST_WAIT && cnt == 4'd1);
  assign mem_we = commit && c_we && (exc == DM_EXC_NONE);

  dm_wait_ctrl_lane u_lane (
    .old_word (old_word),
    .typ      (c_type),
    .byte_sel (c_addr[1:0]),
    .wdata    (c_wdata),
    .wr_word  (merged),
    .rd_data  (rd_ext)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      written <= '0;
    end else if (mem_we) begin
      written[word_idx] <= 1'b1;
      mem[word_idx]     <= merged;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= ST_IDLE;
      cnt        <= '0;
      req_ready  <= 1'b1;
      resp_valid <= 1'b0;
      resp_rdata <= '0;
      resp_exc   <= DM_EXC_NONE;
      we_q       <= 1'b0;
      type_q     <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      pc_q       <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (req_valid) begin
            we_q      <= req_we;
            type_q    <= req_type;
            addr_q    <= req_addr;
            wdata_q   <= req_wdata;
            pc_q      <= req_pc;
            cnt       <= 4'(LATENCY);
            req_ready <= 1'b0;
            state     <= commit ? ST_RESP : ST_WAIT;
          end
        end
        ST_WAIT: begin
          cnt <= cnt - 4'd1;
          if (commit) state <= ST_RESP;
        end
        ST_RESP: begin
          if (resp_ready) begin
            resp_valid <= 1'b0;
            req_ready  <= 1'b1;
            state      <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase

      if (commit) begin
        resp_valid <= 1'b1;
        resp_exc   <= exc;
        resp_rdata <= (exc == DM_EXC_NONE && !c_we) ? rd_ext : 32'h0;
        if (DISPLAY != 0 && mem_we)
          $display("@%h: *%h <= %h", c_pc, c_addr, merged);
      end
    end
  end

endmodule
